// File: rtl/pmul_scheduler.sv
// Round-robin scheduler sharing one scalar-multiplier datapath between NUM_REQ requesters.
// Accept to rsp_valid is 2+D cycles (1 cycle for k==0); one job in flight, rsp held until rsp_ready.
package elliptic_curve_structs;
  typedef struct packed {
    logic [255:0] x;
    logic [255:0] y;
    logic [255:0] z;
  } curve_point_t;

  localparam curve_point_t inf_point = '{x: 256'd0, y: 256'd1, z: 256'd0};
endpackage

module pmul_scheduler
  import elliptic_curve_structs::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 2**20
) (
  input  logic                             clk,
  input  logic                             Reset,
  input  logic         [NUM_REQ-1:0]       req_valid,
  output logic         [NUM_REQ-1:0]       req_ready,
  input  curve_point_t [NUM_REQ-1:0]       req_P,
  input  logic         [NUM_REQ-1:0][255:0] req_k,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic         [ID_W-1:0]          rsp_id,
  output curve_point_t                     rsp_R,
  output logic                             rsp_err,
  output logic                             mul_reset,
  output curve_point_t                     mul_P,
  output logic         [255:0]             mul_k,
  input  logic                             mul_done,
  input  curve_point_t                     mul_R,
  output logic                             busy
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

  state_t             state, state_nx;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_vld;
  int                 cand;
  logic [CNT_W-1:0]   wd_cnt;
  logic               wd_expired;
  logic [ID_W-1:0]    job_id;
  curve_point_t       job_P;
  logic [255:0]       job_k;

  // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int o = 0; o < NUM_REQ; o++) begin
      cand = (int'(rr_ptr) + o) % NUM_REQ;
      if (!grant_vld && req_valid[ID_W'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(cand);
      end
    end
  end

  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant_idx] = 1'b1;
          state_nx = (req_k[grant_idx] == 256'd0) ? RESP : START;
        end
      end
      START: state_nx = RUN;
      RUN: begin
        if (mul_done || wd_expired) state_nx = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      rr_ptr    <= '0;
      job_id    <= '0;
      job_P     <= '0;
      job_k     <= '0;
      wd_cnt    <= '0;
      rsp_R     <= inf_point;
      rsp_err   <= 1'b0;
      mul_reset <= 1'b0;
    end else begin
      mul_reset <= (state_nx == START);
      case (state)
        IDLE: begin
          if (grant_vld) begin
            job_id  <= grant_idx;
            job_P   <= req_P[grant_idx];
            job_k   <= req_k[grant_idx];
            rsp_R   <= inf_point;
            rsp_err <= 1'b0;
          end
        end
        START: wd_cnt <= '0;
        RUN: begin
          if (mul_done) begin
            rsp_R   <= mul_R;
            rsp_err <= 1'b0;
          end else if (wd_expired) begin
            rsp_R   <= inf_point;
            rsp_err <= 1'b1;
          end else if (wd_cnt != {CNT_W{1'b1}}) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready)
            rr_ptr <= (job_id == ID_W'(NUM_REQ - 1)) ? '0 : job_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The multiplier re-reads k every step, so it sees the job registers directly.
  assign mul_P     = job_P;
  assign mul_k     = job_k;
  assign rsp_id    = job_id;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

endmodule
